// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory req/ack and IF/ID valid/stall.
// The master side is the fetch unit; the slave side is memory plus ID.
interface fetch_unit_if;
  logic        Stall_i;
  logic        Redirect_i;
  logic [31:0] RedirectAddr_i;
  logic        IMemReq_o;
  logic [31:0] IMemAddr_o;
  logic        IMemAck_i;
  logic [31:0] IMemData_i;
  logic        Valid_o;
  logic [31:0] Inst_o;
  logic [31:0] PC4_o;

  modport master (
    input  Stall_i,
    input  Redirect_i,
    input  RedirectAddr_i,
    input  IMemAck_i,
    input  IMemData_i,
    output IMemReq_o,
    output IMemAddr_o,
    output Valid_o,
    output Inst_o,
    output PC4_o
  );

  modport slave (
    output Stall_i,
    output Redirect_i,
    output RedirectAddr_i,
    output IMemAck_i,
    output IMemData_i,
    input  IMemReq_o,
    input  IMemAddr_o,
    input  Valid_o,
    input  Inst_o,
    input  PC4_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack and
// presents one instruction at a time to IF/ID, dropping wrong-path data.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         Clock_i,
  input  logic         Reset_n_i,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    FULL
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] redir;

  assign redir = bus.RedirectAddr_i & 32'hFFFF_FFFC;

  always_ff @(posedge Clock_i) begin
    if (!Reset_n_i) begin
      state_q <= IDLE;
      addr_q  <= RESET_PC;
      pend_q  <= 32'h0;
      inst_q  <= 32'h0;
      pc4_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (bus.Redirect_i) addr_d = redir;
      end
      FETCH: begin
        if (bus.IMemAck_i) begin
          if (bus.Redirect_i) begin
            addr_d = redir;
          end else begin
            inst_d  = bus.IMemData_i;
            pc4_d   = addr_q + 32'd4;
            state_d = FULL;
          end
        end else if (bus.Redirect_i) begin
          // request cannot be withdrawn; park the target
          pend_d  = redir;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.IMemAck_i) begin
          addr_d  = bus.Redirect_i ? redir : pend_q;
          state_d = FETCH;
        end else if (bus.Redirect_i) begin
          pend_d = redir;
        end
      end
      FULL: begin
        if (bus.Redirect_i) begin
          addr_d  = redir;
          state_d = FETCH;
        end else if (!bus.Stall_i) begin
          addr_d  = pc4_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.IMemReq_o  = (state_q == FETCH) || (state_q == DRAIN);
  assign bus.IMemAddr_o = addr_q;
  assign bus.Valid_o    = (state_q == FULL);
  assign bus.Inst_o     = inst_q;
  assign bus.PC4_o      = pc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, variable-latency memory,
// scoreboard of expected instructions checked when Valid_o rises.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] inst;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   mem_wait;
  int   mem_cnt;
  logic prev_v;
  exp_t sb[$];

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .Clock_i  (clk),
    .Reset_n_i(rst_n),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc4, input logic [31:0] inst);
    exp_t e;
    e.pc4  = pc4;
    e.inst = inst;
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // memory: ack after mem_wait wait cycles, data = ~address
  initial begin
    bus.IMemAck_i  = 1'b0;
    bus.IMemData_i = 32'h0;
    mem_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!bus.IMemReq_o) begin
        bus.IMemAck_i = 1'b0;
        mem_cnt = 0;
      end else if (mem_cnt == mem_wait) begin
        bus.IMemAck_i  = 1'b1;
        bus.IMemData_i = ~bus.IMemAddr_o;
        mem_cnt = 0;
      end else begin
        bus.IMemAck_i = 1'b0;
        mem_cnt++;
      end
    end
  end

  initial begin
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      chk("inv_valid_req", {31'b0, bus.Valid_o & bus.IMemReq_o}, 32'h0);
      if (bus.Valid_o && !prev_v) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got pc4 %h expected none",
                   bus.PC4_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_inst", bus.Inst_o, e.inst);
          chk("sb_pc4", bus.PC4_o, e.pc4);
        end
      end
      prev_v = bus.Valid_o;
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    mem_wait = 0;
    bus.Stall_i = 1'b0;
    bus.Redirect_i = 1'b0;
    bus.RedirectAddr_i = 32'h0;

    step(); step();
    chk("rst_req", {31'b0, bus.IMemReq_o}, 32'h0);
    chk("rst_addr", bus.IMemAddr_o, 32'h0);
    chk("rst_valid", {31'b0, bus.Valid_o}, 32'h0);
    chk("rst_inst", bus.Inst_o, 32'h0);
    chk("rst_pc4", bus.PC4_o, 32'h0);
    rst_n = 1'b1;
    push(32'h4, 32'hFFFF_FFFF);
    push(32'h8, 32'hFFFF_FFFB);
    push(32'hC, 32'hFFFF_FFF7);

    step();
    chk("z_req0", {31'b0, bus.IMemReq_o}, 32'h1);
    chk("z_addr0", bus.IMemAddr_o, 32'h0);
    step();
    chk("z_valid0", {31'b0, bus.Valid_o}, 32'h1);
    chk("z_pc4_0", bus.PC4_o, 32'h4);
    step();
    chk("z_req1", {31'b0, bus.IMemReq_o}, 32'h1);
    chk("z_addr1", bus.IMemAddr_o, 32'h4);
    step();
    chk("z_valid1", {31'b0, bus.Valid_o}, 32'h1);
    chk("z_pc4_1", bus.PC4_o, 32'h8);
    mem_wait = 3;

    for (int i = 0; i < 4; i++) begin
      step();
      chk("w_req", {31'b0, bus.IMemReq_o}, 32'h1);
      chk("w_addr", bus.IMemAddr_o, 32'h8);
      chk("w_valid", {31'b0, bus.Valid_o}, 32'h0);
    end
    step();
    chk("w_valid_after", {31'b0, bus.Valid_o}, 32'h1);
    chk("w_pc4", bus.PC4_o, 32'hC);
    bus.Stall_i = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step();
      chk("s_valid", {31'b0, bus.Valid_o}, 32'h1);
      chk("s_req", {31'b0, bus.IMemReq_o}, 32'h0);
      chk("s_inst", bus.Inst_o, 32'hFFFF_FFF7);
      chk("s_pc4", bus.PC4_o, 32'hC);
    end
    bus.Stall_i = 1'b0;
    mem_wait = 0;
    push(32'h10, 32'hFFFF_FFF3);
    step();
    chk("s_next_addr", bus.IMemAddr_o, 32'hC);
    chk("s_next_req", {31'b0, bus.IMemReq_o}, 32'h1);
    step();
    chk("s_next_pc4", bus.PC4_o, 32'h10);
    mem_wait = 5;

    step();
    chk("r_out_req", {31'b0, bus.IMemReq_o}, 32'h1);
    chk("r_out_addr", bus.IMemAddr_o, 32'h10);
    rst_n = 1'b0;
    step();
    chk("r_req", {31'b0, bus.IMemReq_o}, 32'h0);
    chk("r_valid", {31'b0, bus.Valid_o}, 32'h0);
    chk("r_inst", bus.Inst_o, 32'h0);
    chk("r_pc4", bus.PC4_o, 32'h0);
    rst_n = 1'b1;
    mem_wait = 0;
    push(32'h4, 32'hFFFF_FFFF);
    step();
    chk("r_first_req", {31'b0, bus.IMemReq_o}, 32'h1);
    chk("r_first_addr", bus.IMemAddr_o, 32'h0);
    step();
    chk("r_first_valid", {31'b0, bus.Valid_o}, 32'h1);
    mem_wait = 2;
    push(32'h104, 32'hFFFF_FEFF);

    step();
    chk("d_addr", bus.IMemAddr_o, 32'h4);
    bus.Redirect_i = 1'b1;
    bus.RedirectAddr_i = 32'h100;
    step();
    bus.Redirect_i = 1'b0;
    chk("d_req_a", {31'b0, bus.IMemReq_o}, 32'h1);
    chk("d_addr_a", bus.IMemAddr_o, 32'h4);
    chk("d_valid_a", {31'b0, bus.Valid_o}, 32'h0);
    step();
    chk("d_req_b", {31'b0, bus.IMemReq_o}, 32'h1);
    chk("d_addr_b", bus.IMemAddr_o, 32'h4);
    chk("d_valid_b", {31'b0, bus.Valid_o}, 32'h0);
    mem_wait = 0;
    step();
    chk("d_new_req", {31'b0, bus.IMemReq_o}, 32'h1);
    chk("d_new_addr", bus.IMemAddr_o, 32'h100);
    chk("d_discard", {31'b0, bus.Valid_o}, 32'h0);
    step();
    chk("d_pc4", bus.PC4_o, 32'h104);

    bus.Stall_i = 1'b1;
    bus.Redirect_i = 1'b1;
    bus.RedirectAddr_i = 32'h203;
    push(32'h204, 32'hFFFF_FDFF);
    step();
    bus.Redirect_i = 1'b0;
    bus.Stall_i = 1'b0;
    chk("f_valid", {31'b0, bus.Valid_o}, 32'h0);
    chk("f_req", {31'b0, bus.IMemReq_o}, 32'h1);
    chk("f_addr", bus.IMemAddr_o, 32'h200);
    step();
    chk("f_pc4", bus.PC4_o, 32'h204);

    bus.Redirect_i = 1'b1;
    bus.RedirectAddr_i = 32'hFFFF_FFFC;
    push(32'h0, 32'h0000_0003);
    step();
    bus.Redirect_i = 1'b0;
    chk("wrap_addr", bus.IMemAddr_o, 32'hFFFF_FFFC);
    step();
    chk("wrap_valid", {31'b0, bus.Valid_o}, 32'h1);
    chk("wrap_pc4", bus.PC4_o, 32'h0);
    bus.Stall_i = 1'b1;
    step();
    step();
    chk("sb_drained", sb.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues requests to the instruction memory over a req/ack interface with variable latency.
- Presents each fetched instruction and its PC+4 to IF/ID using a valid/stall handshake.
- Accepts branch/jump redirects from ID and discards any in-flight or buffered wrong-path fetch.

Parameters:
RESET_PC, 32'h0000_0000, address of the first fetch after reset.

Ports:
Clock_i  in  1  clock; all state updates on posedge.
Reset_n_i  in  1  synchronous reset, active low.
Stall_i  in  1  downstream not ready; IF/ID must not load this cycle.
Redirect_i  in  1  branch/jump taken; the current fetch stream is wrong-path.
RedirectAddr_i  in  32  redirect target; bits [1:0] are ignored and treated as 0.
IMemReq_o  out  1  instruction memory request.
IMemAddr_o  out  32  request address, word aligned.
IMemAck_i  in  1  memory response valid; sampled at posedge while IMemReq_o=1.
IMemData_i  in  32  instruction data, valid when IMemAck_i=1.
Valid_o  out  1  Inst_o/PC4_o hold a valid instruction.
Inst_o  out  32  fetched instruction.
PC4_o  out  32  fetched address + 4.

Behaviour:
- Reset (Reset_n_i=0 at posedge):
  - state=IDLE; IMemReq_o=0; IMemAddr_o=RESET_PC; Valid_o=0; Inst_o=0; PC4_o=0; pending-redirect register cleared.
  - Reset overrides every other input and aborts any outstanding request; the memory must tolerate dropped requests on reset.
- States and transitions:
  - IDLE: IMemReq_o=0. Next cycle go to FETCH. If Redirect_i is high, IMemAddr_o<=RedirectAddr_i.
  - FETCH: IMemReq_o=1; IMemAddr_o is held stable until ack.
    - Ack, no redirect: Inst_o<=IMemData_i; PC4_o<=IMemAddr_o+4; Valid_o<=1; go to FULL.
    - Ack with Redirect_i: discard the data; IMemAddr_o<=RedirectAddr_i; stay in FETCH.
    - Redirect_i, no ack: latch the target into the pending register; go to DRAIN. IMemReq_o stays 1 and the address is unchanged, because the protocol forbids withdrawing a request.
  - DRAIN: IMemReq_o=1 at the old address; Valid_o=0.
    - Redirect_i: the pending register takes the newest target (last redirect wins).
    - Ack: discard the data; IMemAddr_o<=pending (or RedirectAddr_i if Redirect_i is high that cycle); go to FETCH.
  - FULL: IMemReq_o=0; Valid_o=1; Inst_o and PC4_o are held.
    - Redirect_i: Valid_o<=0; IMemAddr_o<=RedirectAddr_i; go to FETCH. Redirect has priority over Stall_i.
    - Stall_i=0: the instruction transfers to IF/ID at this edge; Valid_o<=0; IMemAddr_o<=PC4_o; go to FETCH.
    - Stall_i=1: hold everything, for any number of cycles.
- Handshake:
  - A transfer happens at a posedge with Valid_o=1, Stall_i=0, Redirect_i=0.
  - The IF/ID write enable is driven by Valid_o & ~Stall_i.
  - IF/ID Flush is driven by Redirect_i externally; this block never drives flush.
- Latency and throughput:
  - Memory with ack in the first request cycle: request at cycle N, Valid_o at N+1, next request at N+2.
  - Peak rate is 1 instruction per 2 cycles; each memory wait cycle adds 1 cycle.
- Arithmetic: PC+4 is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Invariants:
  - Valid_o=1 only in FULL.
  - IMemReq_o=1 only in FETCH and DRAIN.
  - Inst_o and PC4_o change only on an accepted ack.
  - A wrong-path instruction is never presented with Valid_o=1.
  - IMemAck_i while IMemReq_o=0 is ignored.

Test Plan:
- Reset then zero-wait memory (ack same cycle), Stall_i=0 → IMemAddr_o sequence 0,4,8 on alternating cycles; Valid_o pulses with PC4_o=4,8,12.
- Memory with 3 wait cycles at addr 8 → IMemReq_o=1 and IMemAddr_o=8 held for 4 cycles; Valid_o rises the cycle after ack with PC4_o=12.
- Valid_o=1 with Stall_i=1 for 5 cycles → Inst_o and PC4_o constant and IMemReq_o=0; on Stall_i=0 the next request goes to PC4_o.
- Redirect_i=1 to 32'h100 during a 2-wait fetch at addr 4 → DRAIN; the ack data is discarded with Valid_o=0; next request at 32'h100; Valid_o then reports PC4_o=32'h104.
- Redirect_i in FULL with Stall_i=1, target 32'h203 → Valid_o drops next cycle and the request goes to 32'h200 (low bits masked).
- Reset_n_i=0 while a request is outstanding → next cycle IMemReq_o=0, Valid_o=0, Inst_o=0, PC4_o=0; the first post-reset request is at RESET_PC.
